mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a fetch port and a data port share one RAM.
// Data requests normally win; a fetch that keeps losing is forced through.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        imemRen,
  input  logic [31:0] imemaddr,
  input  logic        dmmRen,
  input  logic        dmmWen,
  input  logic [31:0] dmmaddr,
  input  logic [31:0] dmmstore,
  output logic        i_ready,
  output logic [31:0] imemload,
  output logic        d_ready,
  output logic [31:0] dmmload,
  output logic        Ren,
  output logic        Wen,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DREAD  = 3'd2,
    DWRITE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  starve_q, starve_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmmload_q, dmmload_d;

  logic        data_pend_s;
  logic        data_win_s;

  function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
    if (cnt == 2'd3) begin
      return cnt;
    end else begin
      return cnt + 2'd1;
    end
  endfunction

  // A data request also wins when no fetch is waiting, so data never stalls
  // behind a saturated starve count with nothing to starve.
  assign data_pend_s = dmmRen | dmmWen;
  assign data_win_s  = data_pend_s &
                       ((32'(starve_q) < STARVE_LIMIT) | ~imemRen);

  // Next state plus next value of every registered output.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    ren_d      = ren_q;
    wen_d      = wen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    i_ready_d  = 1'b0;
    d_ready_d  = 1'b0;
    imemload_d = imemload_q;
    dmmload_d  = dmmload_q;

    case (state_q)
      IDLE: begin
        if (data_win_s) begin
          state_d    = dmmWen ? DWRITE : DREAD;
          ren_d      = ~dmmWen;
          wen_d      = dmmWen;
          ramaddr_d  = dmmaddr;
          ramstore_d = dmmWen ? dmmstore : 32'd0;
          starve_d   = imemRen ? sat_inc(starve_q) : 2'd0;
        end else if (imemRen) begin
          state_d    = IFETCH;
          ren_d      = 1'b1;
          wen_d      = 1'b0;
          ramaddr_d  = imemaddr;
          ramstore_d = 32'd0;
          starve_d   = 2'd0;
        end else begin
          ren_d      = 1'b0;
          wen_d      = 1'b0;
          ramaddr_d  = 32'd0;
          ramstore_d = 32'd0;
        end
      end

      IFETCH, DREAD, DWRITE: begin
        if (!busy_o) begin
          state_d    = DONE;
          ren_d      = 1'b0;
          wen_d      = 1'b0;
          ramaddr_d  = 32'd0;
          ramstore_d = 32'd0;
          if (state_q == IFETCH) begin
            imemload_d = ramload;
            i_ready_d  = 1'b1;
          end else if (state_q == DREAD) begin
            dmmload_d  = ramload;
            d_ready_d  = 1'b1;
          end else begin
            d_ready_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end

      DONE: begin
        state_d    = IDLE;
        ren_d      = 1'b0;
        wen_d      = 1'b0;
        ramaddr_d  = 32'd0;
        ramstore_d = 32'd0;
      end

      default: begin
        state_d    = IDLE;
        ren_d      = 1'b0;
        wen_d      = 1'b0;
        ramaddr_d  = 32'd0;
        ramstore_d = 32'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= IDLE;
      starve_q   <= 2'd0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      ramaddr_q  <= 32'd0;
      ramstore_q <= 32'd0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      imemload_q <= 32'd0;
      dmmload_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      i_ready_q  <= i_ready_d;
      d_ready_q  <= d_ready_d;
      imemload_q <= imemload_d;
      dmmload_q  <= dmmload_d;
    end
  end

  assign Ren      = ren_q;
  assign Wen      = wen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign i_ready  = i_ready_q;
  assign d_ready  = d_ready_q;
  assign imemload = imemload_q;
  assign dmmload  = dmmload_q;

endmodule
